// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with fill level, almost-full/empty thresholds,
// optional first-word-fall-through read and optional rising-edge request detection.
module fifo_param #(
    parameter int unsigned D_WIDTH  = 8,
    parameter int unsigned A_WIDTH  = 5,
    parameter int unsigned AF_LEVEL = 28,
    parameter int unsigned AE_LEVEL = 4,
    parameter int unsigned FWFT     = 0,
    parameter int unsigned EDGE_DET = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd,
    input  logic               wr,
    input  logic [D_WIDTH-1:0] data_in,
    output logic [D_WIDTH-1:0] data_out,
    output logic               full,
    output logic               empty,
    output logic               almost_full,
    output logic               almost_empty,
    output logic [A_WIDTH:0]   level,
    output logic               err_ovf,
    output logic               err_unf
);

    localparam int unsigned DEPTH = 2 ** A_WIDTH;

    typedef logic [A_WIDTH-1:0] ptr_t;
    typedef logic [A_WIDTH:0]   lvl_t;
    typedef logic [D_WIDTH-1:0] word_t;

    word_t mem [DEPTH];

    ptr_t  rd_ptr_q, rd_ptr_d;
    ptr_t  wr_ptr_q, wr_ptr_d;
    lvl_t  level_q, level_d;
    word_t dout_q, dout_d;
    logic  rd_q, wr_q;
    logic  err_ovf_q, err_ovf_d;
    logic  err_unf_q, err_unf_d;

    logic  rd_i, wr_i, rd_acc, wr_acc;

    // Status flags come straight from the registered level.
    assign full         = (level_q == lvl_t'(DEPTH));
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= lvl_t'(AF_LEVEL));
    assign almost_empty = (level_q <= lvl_t'(AE_LEVEL));
    assign level        = level_q;
    assign err_ovf      = err_ovf_q;
    assign err_unf      = err_unf_q;

    // FWFT presents the head word continuously; otherwise the read register.
    assign data_out = (FWFT != 0) ? mem[rd_ptr_q] : dout_q;

    always_comb begin
        rd_i      = (EDGE_DET != 0) ? (rd & ~rd_q) : rd;
        wr_i      = (EDGE_DET != 0) ? (wr & ~wr_q) : wr;
        rd_acc    = rd_i & ~empty;
        wr_acc    = wr_i & (~full | rd_acc);

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        dout_d    = dout_q;
        err_ovf_d = wr_i & ~wr_acc;
        err_unf_d = rd_i & ~rd_acc;
        level_d   = level_q + lvl_t'(wr_acc) - lvl_t'(rd_acc);

        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + ptr_t'(1);
            dout_d   = mem[rd_ptr_q];
        end
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ptr_t'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            level_q   <= '0;
            dout_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            level_q   <= level_d;
            dout_q    <= dout_d;
            rd_q      <= rd;
            wr_q      <= wr;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
        end
    end

    // Storage is not reset; reset only discards it through the pointers.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

endmodule
